aes128_stream_loader: RTL and testbench

- Upstream feeder and result capture for the fully combinational aes128 core.
- Assembles four 32-bit plaintext words from a valid/ready stream into one 128-bit block, holds it with the round key on the core inputs for a multicycle settle window, then captures the core result.
- Returns the ciphertext as four 32-bit words on a second valid/ready stream.
- Lets the combinational core run as a declared multicycle path under a synchronous system clock.

---
 rtl/aes128_stream_loader.sv | 189 ++++++++++++++++++
 tb/tb_aes128_stream_loader.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_stream_loader.sv
// -----------------------------------------------------------------------------
// aes128_stream_loader
//
// Feeds a fully combinational AES-128 core and captures its result. Four 32-bit
// plaintext words arrive on a valid/ready stream and are packed into one
// 128-bit block (first word in bits [127:96]). The block and the round key are
// then held unchanged on the core inputs for SETTLE_CYCLES clocks. After that
// the core output is registered and sent back out as four 32-bit words on a
// second valid/ready stream, in the same word order.
//
// Only the plaintext/key registers -> core -> result register paths are
// multicycle paths. Every other path in this block is single cycle.
//
// Parameters
//   SETTLE_CYCLES  clocks the core inputs are held before capture (1..15)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   key_load       write key_value into the key register when key_ready=1
//   key_value      128-bit cipher key
//   key_ready      key register may be written (LOAD state, no words held)
//   in_valid       plaintext word valid
//   in_ready       plaintext word accepted when in_valid=1
//   in_data        plaintext word
//   out_valid      ciphertext word valid
//   out_ready      downstream accepts ciphertext word
//   out_data       ciphertext word
//   core_data_in   plaintext block to the core
//   core_key_in    key to the core
//   core_data_out  ciphertext block from the core
//   busy           high while settling or draining
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------------
//   LOAD    | collecting plaintext words; key may be written between blocks
//   SETTLE  | core inputs frozen, settle counter running toward capture
//   DRAIN   | result register streamed out word by word
// -----------------------------------------------------------------------------
module aes128_stream_loader #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_value,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  input  logic [127:0] core_data_out,
  output logic         busy
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  // The counter is loaded with SETTLE_CYCLES-1 on the 4th-word edge and the
  // capture happens on the edge where it reads zero, which is SETTLE_CYCLES
  // edges after the 4th-word edge.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]   state;
  logic [1:0]   word_cnt;
  logic [1:0]   out_idx;
  logic [3:0]   settle_cnt;
  logic         key_valid;
  logic [127:0] key_reg;
  logic [127:0] pt_reg;
  logic [127:0] res_reg;

  logic         key_accept;
  logic         in_hs;
  logic         out_hs;
  logic         capture;

  // The state register reads LOAD while reset is held. Gating with rst_n keeps
  // key_ready at 0 during reset and lets it rise as soon as reset releases.
  assign key_ready  = rst_n && (state == S_LOAD) && (word_cnt == 2'd0);
  assign key_accept = key_load && key_ready;

  // A word is never taken on the same cycle as a key write. This keeps a
  // block from mixing words stored under two different keys.
  assign in_ready   = (state == S_LOAD) && key_valid && !key_accept;
  assign in_hs      = in_valid && in_ready;

  assign out_valid  = (state == S_DRAIN);
  assign out_hs     = out_valid && out_ready;

  assign busy       = (state == S_SETTLE) || (state == S_DRAIN);
  assign capture    = (state == S_SETTLE) && (settle_cnt == 4'd0);

  assign core_data_in = pt_reg;
  assign core_key_in  = key_reg;

  always_comb begin
    out_data = res_reg[127:96];
    case (out_idx)
      2'd0:    out_data = res_reg[127:96];
      2'd1:    out_data = res_reg[95:64];
      2'd2:    out_data = res_reg[63:32];
      default: out_data = res_reg[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      word_cnt   <= 2'd0;
      settle_cnt <= 4'd0;
      out_idx    <= 2'd0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_hs) begin
            if (word_cnt == 2'd3) begin
              word_cnt   <= 2'd0;
              settle_cnt <= SETTLE_INIT;
              state      <= S_SETTLE;
            end else begin
              word_cnt <= word_cnt + 2'd1;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            out_idx <= 2'd0;
            state   <= S_DRAIN;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_DRAIN: begin
          if (out_hs) begin
            out_idx <= out_idx + 2'd1;
            if (out_idx == 2'd3) begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Key register. It is only writable between blocks, so it stays constant
  // while the core settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg   <= 128'd0;
      key_valid <= 1'b0;
    end else if (key_accept) begin
      key_reg   <= key_value;
      key_valid <= 1'b1;
    end
  end

  // Plaintext register. It is written only by input handshakes, which cannot
  // happen outside LOAD, so the core inputs stay frozen during SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_reg <= 128'd0;
    end else if (in_hs) begin
      case (word_cnt)
        2'd0:    pt_reg[127:96] <= in_data;
        2'd1:    pt_reg[95:64]  <= in_data;
        2'd2:    pt_reg[63:32]  <= in_data;
        default: pt_reg[31:0]   <= in_data;
      endcase
    end
  end

  // Endpoint of the multicycle path from the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reg <= 128'd0;
    end else if (capture) begin
      res_reg <= core_data_out;
    end
  end

endmodule

// File: tb/tb_aes128_stream_loader.sv
module tb_aes128_stream_loader;

  localparam int S = 4;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk;
  logic         rst_n;
  logic         key_load;
  logic [127:0] key_value;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [127:0] core_data_in;
  logic [127:0] core_key_in;
  logic [127:0] core_data_out;
  logic         busy;

  int n_cmp;
  int n_err;

  // ---------------- behavioural AES-128 (core stand-in and reference) -------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] q;
    r = 8'h01;
    q = a;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) r = gmul(r, q);
      q = gmul(q, q);
    end
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] st;
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb(st[127-8*i -: 8]);
      for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i];
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  assign core_data_out = aes_enc(core_data_in, core_key_in);

  aes128_stream_loader #(.SETTLE_CYCLES(S)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_load      (key_load),
    .key_value     (key_value),
    .key_ready     (key_ready),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .core_data_in  (core_data_in),
    .core_key_in   (core_key_in),
    .core_data_out (core_data_out),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helpers ----------------
  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_k(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Sampled 3 time units after each rising edge. Inputs are driven at +1.
  // Handshakes seen here take effect on the following edge.
  int           cyc;
  bit           kv_m;
  logic [127:0] key_m;
  logic [31:0]  pt_m [4];
  logic [31:0]  words_q [$];
  logic [31:0]  exp_q [$];
  int           ready_cyc;
  int           last_drain_cyc;
  int           start_gap;
  bit           busy_e, kr_e, ir_e, ov_e;
  logic [127:0] blk_m;

  always @(posedge clk) begin
    #3;
    cyc++;
    if (!rst_n) begin
      chk_b("rst_key_ready", key_ready, 1'b0);
      chk_b("rst_in_ready", in_ready, 1'b0);
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_w("rst_out_data", out_data, 32'h0);
      chk_k("rst_core_data_in", core_data_in, 128'h0);
      chk_k("rst_core_key_in", core_key_in, 128'h0);
      kv_m  = 1'b0;
      key_m = 128'h0;
      for (int i = 0; i < 4; i++) pt_m[i] = 32'h0;
      words_q.delete();
      exp_q.delete();
    end else begin
      busy_e = (exp_q.size() != 0);
      kr_e   = !busy_e && (words_q.size() == 0);
      ir_e   = kv_m && !busy_e && !(key_load && kr_e);
      ov_e   = busy_e && (cyc >= ready_cyc);
      chk_b("key_ready", key_ready, kr_e);
      chk_b("in_ready", in_ready, ir_e);
      chk_b("out_valid", out_valid, ov_e);
      chk_b("busy", busy, busy_e);
      if (ov_e) chk_w("out_data", out_data, exp_q[0]);
      chk_k("core_key_in", core_key_in, key_m);
      chk_k("core_data_in", core_data_in, {pt_m[0], pt_m[1], pt_m[2], pt_m[3]});

      if (key_load && kr_e) begin
        key_m = key_value;
        kv_m  = 1'b1;
      end
      if (in_valid && ir_e) begin
        if (words_q.size() == 0) start_gap = cyc - last_drain_cyc;
        pt_m[words_q.size()] = in_data;
        words_q.push_back(in_data);
        if (words_q.size() == 4) begin
          blk_m = aes_enc({words_q[0], words_q[1], words_q[2], words_q[3]}, key_m);
          for (int i = 0; i < 4; i++) exp_q.push_back(blk_m[127-32*i -: 32]);
          ready_cyc = cyc + S + 1;
          words_q.delete();
        end
      end
      if (out_ready && ov_e) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) last_drain_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    bit got;
    got       = 1'b0;
    key_value = k;
    key_load  = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      #2;
      got = key_ready;
      step();
    end
    key_load = 1'b0;
    chk_b("load_key_accepted", got, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 100 && !got; n++) begin
      #2;
      got = in_ready;
      step();
    end
    chk_b("send_word_accepted", got, 1'b1);
  endtask

  task automatic send_block(input logic [127:0] p);
    for (int i = 0; i < 4; i++) send_word(p[127-32*i -: 32]);
  endtask

  task automatic recv_word(output logic [31:0] w, input int stall, output int waited);
    bit got;
    got       = 1'b0;
    w         = 32'h0;
    waited    = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      #2;
      if (out_valid) begin
        w   = out_data;
        got = 1'b1;
      end else begin
        waited++;
      end
      step();
    end
    out_ready = 1'b0;
    chk_b("recv_word_seen", got, 1'b1);
    repeat (stall) step();
  endtask

  task automatic recv_block(output logic [127:0] blk, input int stall, output int lat);
    logic [31:0] w;
    int          wt;
    blk = 128'h0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      recv_word(w, stall, wt);
      if (i == 0) lat = wt;
      blk[127-32*i -: 32] = w;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_b("async_rst_key_ready", key_ready, 1'b0);
    chk_b("async_rst_out_valid", out_valid, 1'b0);
    chk_b("async_rst_busy", busy, 1'b0);
    chk_w("async_rst_out_data", out_data, 32'h0);
    chk_k("async_rst_core_data_in", core_data_in, 128'h0);
    chk_k("async_rst_core_key_in", core_key_in, 128'h0);
    step();
    step();
    rst_n = 1'b1;
    #2;
    chk_b("key_ready_after_release", key_ready, 1'b1);
    chk_b("in_ready_after_release", in_ready, 1'b0);
    step();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           stall;
  } vec_t;

  vec_t         vt [3];
  logic [127:0] r1, r2, rb, p2, kcur, prand;
  int           l1, l2, lat, n_ir, n_ov;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 0};
    vt[1] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 10};
    vt[2] = '{128'h0, 128'h0, ZERO_CT, 0};

    n_cmp = 0; n_err = 0; cyc = 0;
    kv_m = 1'b0; key_m = 128'h0; ready_cyc = 0; last_drain_cyc = 0; start_gap = 0;
    for (int i = 0; i < 4; i++) pt_m[i] = 32'h0;
    rst_n = 1'b1; key_load = 1'b0; key_value = 128'h0;
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // No key loaded: words are refused and nothing comes out.
    n_ir = 0; n_ov = 0;
    in_valid = 1'b1;
    in_data  = $urandom;
    repeat (20) begin
      #2;
      if (in_ready) n_ir++;
      if (out_valid) n_ov++;
      step();
    end
    chk_w("nokey_in_ready_count", 32'(n_ir), 32'd0);
    chk_w("nokey_out_valid_count", 32'(n_ov), 32'd0);
    in_valid = 1'b0;
    load_key(FIPS_KEY);
    in_valid = 1'b1;
    in_data  = FIPS_PT[127:96];
    #2;
    chk_b("in_ready_after_key", in_ready, 1'b1);
    step();
    for (int i = 1; i < 4; i++) send_word(FIPS_PT[127-32*i -: 32]);
    in_valid = 1'b0;
    recv_block(rb, 0, lat);
    chk_k("nokey_then_key_ct", rb, FIPS_CT);

    // Table-driven vectors: FIPS, FIPS with backpressure, all-zero key.
    for (int v = 0; v < 3; v++) begin
      load_key(vt[v].key);
      send_block(vt[v].pt);
      in_valid = 1'b0;
      recv_block(rb, vt[v].stall, lat);
      chk_k("vec_ct", rb, vt[v].ct);
      chk_w("vec_latency", 32'(lat), 32'(S));
    end

    // Key writes attempted mid-block and during settle are ignored.
    load_key(FIPS_KEY);
    send_word(FIPS_PT[127:96]);
    send_word(FIPS_PT[95:64]);
    in_valid  = 1'b0;
    key_value = ~128'h0;
    key_load  = 1'b1;
    #2;
    chk_b("key_ready_midblock", key_ready, 1'b0);
    step();
    key_load = 1'b0;
    send_word(FIPS_PT[63:32]);
    send_word(FIPS_PT[31:0]);
    in_valid  = 1'b0;
    key_value = 128'h0;
    key_load  = 1'b1;
    #2;
    chk_b("key_ready_settle", key_ready, 1'b0);
    step();
    key_load = 1'b0;
    recv_block(rb, 0, lat);
    chk_k("key_ignored_ct", rb, FIPS_CT);

    // Back-to-back blocks with in_valid held high.
    p2 = {$urandom, $urandom, $urandom, $urandom};
    fork
      begin
        send_block(FIPS_PT);
        send_block(p2);
        in_valid = 1'b0;
      end
      begin
        recv_block(r1, 0, l1);
        recv_block(r2, 0, l2);
      end
    join
    chk_k("b2b_ct1", r1, FIPS_CT);
    chk_k("b2b_ct2", r2, aes_enc(p2, FIPS_KEY));
    chk_w("b2b_start_gap", 32'(start_gap), 32'd1);

    // Reset during SETTLE.
    send_block({$urandom, $urandom, $urandom, $urandom});
    in_valid = 1'b0;
    step();
    step();
    do_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    load_key(FIPS_KEY);
    send_block(FIPS_PT);
    in_valid = 1'b0;
    recv_block(rb, 0, lat);
    chk_k("after_settle_reset_ct", rb, FIPS_CT);

    // Reset during DRAIN.
    send_block(FIPS_PT);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (S + 3) step();
    #2;
    chk_b("drain_before_reset", out_valid, 1'b1);
    step();
    do_reset();
    n_ov = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      #2;
      if (out_valid) n_ov++;
      step();
    end
    chk_w("no_stale_words", 32'(n_ov), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    load_key(128'h0);
    send_block(128'h0);
    in_valid = 1'b0;
    recv_block(rb, 0, lat);
    chk_k("after_drain_reset_ct", rb, ZERO_CT);

    // Randomized blocks, keys, gaps and stalls.
    kcur = 128'h0;
    for (int b = 0; b < 25; b++) begin
      if (b == 0 || $urandom_range(0, 2) == 0) begin
        kcur = {$urandom, $urandom, $urandom, $urandom};
        load_key(kcur);
      end
      prand = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        send_word(prand[127-32*i -: 32]);
      end
      in_valid = 1'b0;
      recv_block(rb, $urandom_range(0, 3), lat);
      chk_k("rand_ct", rb, aes_enc(prand, kcur));
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
